// File: rtl/serial_adder_nbit.sv
// rtl/serial_adder_nbit.sv - digit-serial WIDTH-bit adder with valid/ready handshakes
//
// Purpose: adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock,
// LSB slice first, through one registered carry. The result holds until the
// consumer takes it.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the InSub port
// (InSub = 1 computes A - B - InC as A + ~B + !InC).
//
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-high reset
//   InA, InB, InC     operands and carry-in, taken when InValid & InReady
//   InSub             subtract select (only with SERIAL_ADDER_SUB_EN)
//   InValid, InReady  input handshake; InReady is high only in IDLE
//   OutSum            sum modulo 2^WIDTH
//   OutC, OutOvf      unsigned carry-out, signed overflow
//   OutValid,OutReady output handshake; OutValid is registered
module serial_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             InC,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             InSub,
`endif
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutSum,
  output logic             OutC,
  output logic             OutOvf,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
      $error("serial_adder_nbit: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sumQ;
  logic             cQ;
  logic             ovfQ;
  logic             validQ;

  logic [WIDTH-1:0] bIn;
  logic             cIn;
  logic [DIGIT-1:0] aSlice;
  logic [DIGIT-1:0] bSlice;
  logic [DIGIT-1:0] sSlice;
  logic             cSlice;
  logic             ovfSlice;
  logic             lastSlice;

  // Subtraction is folded into the operands at accept time so the slice
  // datapath only ever adds.
`ifdef SERIAL_ADDER_SUB_EN
  assign bIn = InSub ? ~InB : InB;
  assign cIn = InSub ? ~InC : InC;
`else
  assign bIn = InB;
  assign cIn = InC;
`endif

  // Operands shift right each RUN cycle, so the current slice is always
  // the low DIGIT bits and no wide index mux is needed on the adder path.
  assign aSlice = opA[DIGIT-1:0];
  assign bSlice = opB[DIGIT-1:0];
  assign {cSlice, sSlice} = {1'b0, aSlice} + {1'b0, bSlice} + {{DIGIT{1'b0}}, carry};

  // Same-sign operands producing an opposite-sign result is exactly
  // carry-into-MSB XOR carry-out-of-MSB; only meaningful on the last slice.
  assign ovfSlice  = (aSlice[DIGIT-1] ~^ bSlice[DIGIT-1]) & (sSlice[DIGIT-1] ^ aSlice[DIGIT-1]);
  assign lastSlice = (idx == IDXW'(N - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (InValid)   stateNext = RUN;
      RUN:     if (lastSlice) stateNext = DONE;
      DONE:    if (OutReady)  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      opA    <= '0;
      opB    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sumQ   <= '0;
      cQ     <= 1'b0;
      ovfQ   <= 1'b0;
      validQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            opA   <= InA;
            opB   <= bIn;
            carry <= cIn;
            idx   <= '0;
          end
        end
        RUN: begin
          opA   <= opA >> DIGIT;
          opB   <= opB >> DIGIT;
          carry <= cSlice;
          idx   <= idx + IDXW'(1);
          for (int k = 0; k < N; k++) begin
            if (idx == IDXW'(k)) begin
              sumQ[k*DIGIT +: DIGIT] <= sSlice;
            end
          end
          if (lastSlice) begin
            cQ     <= cSlice;
            ovfQ   <= ovfSlice;
            validQ <= 1'b1;
          end
        end
        DONE: begin
          if (OutReady) begin
            validQ <= 1'b0;
          end
        end
        default: begin
          validQ <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = (state == IDLE);
  assign OutSum   = sumQ;
  assign OutC     = cQ;
  assign OutOvf   = ovfQ;
  assign OutValid = validQ;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb/tb_serial_adder_nbit.sv - bench for serial_adder_nbit
`timescale 1ns/1ps
module tb_serial_adder_nbit;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] InA, InB;
  logic         InC, InSub, InValid, OutReady;
  logic         InReady, OutC, OutOvf, OutValid;
  logic [W-1:0] OutSum;

  logic [7:0] a8, b8, sum8;
  logic       c8, sub8, inValid8, outReady8, inReady8, outC8, outOvf8, outValid8;

  int nCmp = 0;
  int nErr = 0;

  always #5 Clk = ~Clk;

  serial_adder_nbit #(.WIDTH(W), .DIGIT(D)) dut (
    .Clk(Clk), .Rst(Rst), .InA(InA), .InB(InB), .InC(InC),
`ifdef SERIAL_ADDER_SUB_EN
    .InSub(InSub),
`endif
    .InValid(InValid), .InReady(InReady), .OutSum(OutSum), .OutC(OutC),
    .OutOvf(OutOvf), .OutValid(OutValid), .OutReady(OutReady)
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .InA(a8), .InB(b8), .InC(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .InSub(sub8),
`endif
    .InValid(inValid8), .InReady(inReady8), .OutSum(sum8), .OutC(outC8),
    .OutOvf(outOvf8), .OutValid(outValid8), .OutReady(outReady8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nCmp++;
    nErr++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Reference arithmetic in plain integers: {ovf, carry/no-borrow, sum}.
  function automatic logic [17:0] refAdd(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic sub);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] s;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = sub ? ua - ub - int'(c) : ua + ub + int'(c);
    sr = sub ? sa - sb - int'(c) : sa + sb + int'(c);
    s  = 16'(ur);
    co = sub ? (ur >= 0) : (ur > 65535);
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Transaction-level model: busy from accept until the output handshake,
  // result visible N edges after accept.
  logic        mBusy, mValid;
  int          mEdges;
  logic [15:0] eSum;
  logic        eC, eO;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mBusy = 1'b0; mValid = 1'b0; mEdges = 0;
      eSum = '0; eC = 1'b0; eO = 1'b0;
    end else if (!mBusy) begin
      if (InValid) begin
        {eO, eC, eSum} = refAdd(InA, InB, InC, InSub);
        mBusy = 1'b1;
        mEdges = 0;
      end
    end else if (mValid) begin
      if (OutReady) begin
        mBusy = 1'b0;
        mValid = 1'b0;
      end
    end else begin
      mEdges++;
      if (mEdges == N) mValid = 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      check("inReady", InReady, !mBusy);
      check("outValid", OutValid, mValid);
      if (!mBusy || mValid) begin
        check("outSum", OutSum, eSum);
        check("outC", OutC, eC);
        check("outOvf", OutOvf, eO);
      end
    end
  end

  task automatic waitReady(input string name);
    int t = 0;
    while (!InReady && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) timeout(name);
  endtask

  task automatic waitValid(input string name, output int lat);
    lat = 0;
    while (!OutValid && lat < 50) begin @(posedge Clk); lat++; @(negedge Clk); end
    if (!OutValid) timeout(name);
  endtask

  task automatic runOne(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic sub, input logic [15:0] expS, input logic expC,
                        input logic expO, input string nm);
    int lat;
    @(negedge Clk);
    InA = a; InB = b; InC = c; InSub = sub; InValid = 1'b1; OutReady = 1'b1;
    waitReady({nm, "Accept"});
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0; InA = 16'($urandom); InB = 16'($urandom); InC = 1'($urandom);
    waitValid({nm, "Valid"}, lat);
    check({nm, "Lat"}, lat, N);
    check({nm, "Sum"}, OutSum, expS);
    check({nm, "C"}, OutC, expC);
    check({nm, "Ovf"}, OutOvf, expO);
  endtask

  initial begin
    int lat;
    Rst = 1'b1; InA = '0; InB = '0; InC = 1'b0; InSub = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0; inValid8 = 1'b0; outReady8 = 1'b1;
    #12;
    check("rstSum", OutSum, 16'h0000);
    check("rstC", OutC, 1'b0);
    check("rstOvf", OutOvf, 1'b0);
    check("rstValid", OutValid, 1'b0);
    check("rstInReady", InReady, 1'b1);
    @(negedge Clk);
    Rst = 1'b0;

    runOne(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    runOne(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    runOne(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovfPos");
    runOne(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "ovfNeg");
`ifdef SERIAL_ADDER_SUB_EN
    runOne(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
    runOne(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "subOvf");
    InSub = 1'b0;
`endif

    // Backpressure: result must hold while a second pair waits.
    @(negedge Clk);
    InA = 16'hABCD; InB = 16'h1111; InC = 1'b0; InValid = 1'b1; OutReady = 1'b0;
    waitReady("bpAccept");
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    waitValid("bpValid", lat);
    InA = 16'h0F0F; InB = 16'h00F1; InC = 1'b1; InValid = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check("bpSum", OutSum, 16'hBCDE);
      check("bpC", OutC, 1'b0);
      check("bpValidHeld", OutValid, 1'b1);
      check("bpInReady", InReady, 1'b0);
    end
    OutReady = 1'b1;
    @(negedge Clk);
    check("bpIdleValid", OutValid, 1'b0);
    check("bpIdleReady", InReady, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    check("bpSecondBusy", InReady, 1'b0);
    waitValid("bp2Valid", lat);
    check("bp2Sum", OutSum, 16'h1001);
    check("bp2C", OutC, 1'b0);

    // Asynchronous reset two cycles into RUN.
    @(negedge Clk);
    InA = 16'h1234; InB = 16'h1111; InC = 1'b0; InValid = 1'b1; OutReady = 1'b1;
    waitReady("rrAccept");
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("rrSum", OutSum, 16'h0000);
    check("rrC", OutC, 1'b0);
    check("rrOvf", OutOvf, 1'b0);
    check("rrValid", OutValid, 1'b0);
    check("rrInReady", InReady, 1'b1);
    @(negedge Clk);
    Rst = 1'b0;
    runOne(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "afterRst");

    // Degenerate single-slice instance.
    @(negedge Clk);
    a8 = 8'hF0; b8 = 8'h10; c8 = 1'b0; inValid8 = 1'b1; outReady8 = 1'b1;
    check("w8Ready", inReady8, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    inValid8 = 1'b0;
    check("w8NotYet", outValid8, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    check("w8Valid", outValid8, 1'b1);
    check("w8Sum", sum8, 8'h00);
    check("w8C", outC8, 1'b1);
    check("w8Ovf", outOvf8, 1'b0);

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      InValid  = ($urandom_range(0, 2) != 0);
      InA      = pick();
      InB      = pick();
      InC      = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      InSub    = 1'($urandom);
`endif
      OutReady = ($urandom_range(0, 3) != 0);
    end
    @(negedge Clk);
    InValid = 1'b0;
    OutReady = 1'b1;
    repeat (10) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
